// File: rtl/vga_frame_scheduler.sv
// Frame-synchronous update scheduler and screen rotator for the VGA pixel generator.
// Optional macro VGA_SCREEN_FORCE_EN adds iforce_en/iforce_screen to pin the displayed screen.
module vga_frame_scheduler #(
  parameter int DWELL_FRAMES = 60,
  parameter int FRAME_CNT_W  = 8
) (
  input  logic        iclock,
  input  logic        ireset,
  input  logic        ivsync,
  input  logic        idat_act_v,
  input  logic        itemp_req,
  input  logic [7:0]  itemp,
  input  logic [4:1]  idig_temp,
  input  logic        iautor_req,
  input  logic [15:0] iautor,
  input  logic        imusica_req,
  input  logic [15:0] imusica,
`ifdef VGA_SCREEN_FORCE_EN
  input  logic        iforce_en,
  input  logic [1:0]  iforce_screen,
`endif
  output logic        otemp_ack,
  output logic        oautor_ack,
  output logic        omusica_ack,
  output logic [7:0]  otemperatura,
  output logic [4:1]  odig_temp,
  output logic [15:0] oautor,
  output logic [15:0] omusica,
  output logic [1:0]  oscreen,
  output logic        oframe_tick
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ACK} state_t;

  localparam logic [FRAME_CNT_W-1:0] LP_LAST = FRAME_CNT_W'(DWELL_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] LP_ONE  = FRAME_CNT_W'(1);

  state_t                 r_state;
  logic [1:0]             r_ptr;
  logic                   r_vs_p0;
  logic                   r_vs_p1;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   w_fall;
  logic [2:0]             w_req;
  logic                   w_gnt_vld;
  logic [1:0]             w_gnt_id;

  // Source index (0 temp, 1 autor, 2 musica) k places after p, modulo 3.
  function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  assign w_fall = r_vs_p1 & ~r_vs_p0;
  assign w_req  = {imusica_req, iautor_req, itemp_req};

  // Scan from farthest to nearest so the requester closest to the pointer wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = r_ptr;
    for (int k = 2; k >= 0; k--) begin
      if (w_req[rr_idx(r_ptr, 2'(k))]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = rr_idx(r_ptr, 2'(k));
      end
    end
  end

  // Stage p0/p1: vsync edge detect, frame tick and screen rotation.
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      r_vs_p0     <= 1'b0;
      r_vs_p1     <= 1'b0;
      oframe_tick <= 1'b0;
      r_frame_cnt <= '0;
      oscreen     <= 2'd0;
    end else begin
      r_vs_p0     <= ivsync;
      r_vs_p1     <= r_vs_p0;
      oframe_tick <= w_fall;
      if (w_fall) begin
`ifdef VGA_SCREEN_FORCE_EN
        if (iforce_en) begin
          oscreen     <= (iforce_screen == 2'd3) ? 2'd0 : iforce_screen;
          r_frame_cnt <= '0;
        end else
`endif
        if (r_frame_cnt == LP_LAST) begin
          r_frame_cnt <= '0;
          oscreen     <= (oscreen == 2'd2) ? 2'd0 : oscreen + 2'd1;
        end else begin
          r_frame_cnt <= r_frame_cnt + LP_ONE;
        end
      end
    end
  end

  // Arbitration FSM: acks are single-cycle, data lands with the ack.
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      r_state      <= S_IDLE;
      r_ptr        <= 2'd0;
      otemp_ack    <= 1'b0;
      oautor_ack   <= 1'b0;
      omusica_ack  <= 1'b0;
      otemperatura <= '0;
      odig_temp    <= '0;
      oautor       <= '0;
      omusica      <= '0;
    end else begin
      otemp_ack   <= 1'b0;
      oautor_ack  <= 1'b0;
      omusica_ack <= 1'b0;
      case (r_state)
        S_IDLE: if (oframe_tick) r_state <= S_ARB;
        S_ARB: begin
          if (!idat_act_v && w_gnt_vld) begin
            r_state <= S_ACK;
            r_ptr   <= rr_idx(w_gnt_id, 2'd1);
            case (w_gnt_id)
              2'd0: begin
                otemp_ack    <= 1'b1;
                otemperatura <= itemp;
                odig_temp    <= idig_temp;
              end
              2'd1: begin
                oautor_ack <= 1'b1;
                oautor     <= iautor;
              end
              default: begin
                omusica_ack <= 1'b1;
                omusica     <= imusica;
              end
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench for vga_frame_scheduler: scoreboard of expected grants plus a screen-rotation model.
module tb_vga_frame_scheduler;
  localparam int DW = 4;

  logic        iclock = 1'b0;
  logic        ireset, ivsync, idat_act_v;
  logic        itemp_req, iautor_req, imusica_req;
  logic [7:0]  itemp;
  logic [4:1]  idig_temp;
  logic [15:0] iautor, imusica;
  logic        otemp_ack, oautor_ack, omusica_ack, oframe_tick;
  logic [7:0]  otemperatura;
  logic [4:1]  odig_temp;
  logic [15:0] oautor, omusica;
  logic [1:0]  oscreen;
`ifdef VGA_SCREEN_FORCE_EN
  logic        iforce_en = 1'b0;
  logic [1:0]  iforce_screen = 2'd0;
`endif

  typedef struct {
    int          id;
    logic [15:0] d;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_temp;
  logic [3:0]  m_dig;
  logic [15:0] m_aut, m_mus;
  logic [1:0]  m_scr;
  int          m_cnt;

  always #5 iclock = ~iclock;

  vga_frame_scheduler #(.DWELL_FRAMES(DW), .FRAME_CNT_W(8)) dut (
    .iclock(iclock), .ireset(ireset), .ivsync(ivsync), .idat_act_v(idat_act_v),
    .itemp_req(itemp_req), .itemp(itemp), .idig_temp(idig_temp),
    .iautor_req(iautor_req), .iautor(iautor), .imusica_req(imusica_req), .imusica(imusica),
`ifdef VGA_SCREEN_FORCE_EN
    .iforce_en(iforce_en), .iforce_screen(iforce_screen),
`endif
    .otemp_ack(otemp_ack), .oautor_ack(oautor_ack), .omusica_ack(omusica_ack),
    .otemperatura(otemperatura), .odig_temp(odig_temp), .oautor(oautor), .omusica(omusica),
    .oscreen(oscreen), .oframe_tick(oframe_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_temp = '0; m_dig = '0; m_aut = '0; m_mus = '0; m_scr = 2'd0; m_cnt = 0;
  endtask

  task automatic screen_tick();
`ifdef VGA_SCREEN_FORCE_EN
    if (iforce_en) begin
      m_scr = (iforce_screen == 2'd3) ? 2'd0 : iforce_screen;
      m_cnt = 0;
      return;
    end
`endif
    if (m_cnt == DW - 1) begin
      m_cnt = 0;
      m_scr = (m_scr == 2'd2) ? 2'd0 : m_scr + 2'd1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic chk_outputs();
    chk("otemperatura", 32'(otemperatura), 32'(m_temp));
    chk("odig_temp", 32'(odig_temp), 32'(m_dig));
    chk("oautor", 32'(oautor), 32'(m_aut));
    chk("omusica", 32'(omusica), 32'(m_mus));
  endtask

  // Pop the next expected grant and check ack, latency and captured data.
  task automatic score_ack(input logic [2:0] acks, input int cyc);
    exp_t e;
    e = q.pop_front();
    chk("ack_which", 32'(acks), 32'(3'b100 >> e.id));
    chk("ack_latency", 32'(cyc), 32'd4);
    case (e.id)
      0: begin m_temp = e.d[7:0]; m_dig = e.d[11:8]; end
      1: m_aut = e.d;
      default: m_mus = e.d;
    endcase
  endtask

  // One frame: vsync low pulse, then 12 sampled cycles. Called on a negedge.
  task automatic frame(input bit act, input bit exp_ack);
    logic [2:0] acks;
    bit seen;
    seen = 1'b0;
    idat_act_v = act;
    ivsync = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge iclock);
      if (i == 2) begin
        ivsync = 1'b1;
        screen_tick();
      end
      chk("oframe_tick", 32'(oframe_tick), 32'(i == 2));
      chk("oscreen", 32'(oscreen), 32'(m_scr));
      acks = {otemp_ack, oautor_ack, omusica_ack};
      if (acks != 3'b000) begin
        chk("ack_expected", 32'(exp_ack && !seen && q.size() != 0), 32'd1);
        if (q.size() != 0) score_ack(acks, i);
        if (acks[2]) itemp_req = 1'b0;
        if (acks[1]) iautor_req = 1'b0;
        if (acks[0]) imusica_req = 1'b0;
        seen = 1'b1;
      end
      chk_outputs();
    end
    if (exp_ack) chk("ack_timeout", 32'(seen), 32'd1);
    idat_act_v = 1'b0;
  endtask

  initial begin
    logic [2:0] acks;
    ireset = 1'b1; ivsync = 1'b1; idat_act_v = 1'b0;
    itemp_req = 1'b0; iautor_req = 1'b0; imusica_req = 1'b0;
    itemp = '0; idig_temp = '0; iautor = '0; imusica = '0;
    model_reset();
    repeat (3) @(negedge iclock);
    chk("rst_acks", 32'({otemp_ack, oautor_ack, omusica_ack}), 32'd0);
    chk("rst_oscreen", 32'(oscreen), 32'd0);
    chk("rst_tick", 32'(oframe_tick), 32'd0);
    chk_outputs();
    ireset = 1'b0;
    repeat (4) @(negedge iclock);

    // Single temperature update.
    itemp_req = 1'b1; itemp = 8'h25; idig_temp = 4'b0011;
    q.push_back('{0, 16'h0325});
    frame(1'b0, 1'b1);

    // Pointer now at autor: both autor and temp request; reset during the autor ack.
    itemp_req = 1'b1; itemp = 8'h5A; idig_temp = 4'b1001;
    iautor_req = 1'b1; iautor = 16'h1234;
    q.push_back('{1, 16'h1234});
    ivsync = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge iclock);
      if (i == 2) begin
        ivsync = 1'b1;
        screen_tick();
      end
    end
    acks = {otemp_ack, oautor_ack, omusica_ack};
    chk("pre_rst_ack", 32'(acks), 32'b010);
    if (q.size() != 0) score_ack(acks, 4);
    #2 ireset = 1'b1;
    #1;
    model_reset();
    chk("midrst_acks", 32'({otemp_ack, oautor_ack, omusica_ack}), 32'd0);
    chk("midrst_oscreen", 32'(oscreen), 32'd0);
    chk_outputs();
    @(negedge iclock);
    ireset = 1'b0;
    repeat (4) @(negedge iclock);

    // Round robin from the reset pointer: temp, autor, musica over three frames.
    imusica_req = 1'b1; imusica = 16'hABCD;
    q.push_back('{0, 16'h095A});
    q.push_back('{1, 16'h1234});
    q.push_back('{2, 16'hABCD});
    repeat (3) frame(1'b0, 1'b1);
    chk("rr_queue_empty", 32'(q.size()), 32'd0);

    // Active video blocks the update; next blanking frame serves it.
    itemp_req = 1'b1; itemp = 8'h81; idig_temp = 4'b0110;
    q.push_back('{0, 16'h0681});
    frame(1'b1, 1'b0);
    chk("blocked_pending", 32'(q.size()), 32'd1);
    frame(1'b0, 1'b1);

    // Idle frames complete 12 ticks since reset: screen 0->1->2->0.
    repeat (7) frame(1'b0, 1'b0);
    chk("rot_12_ticks", 32'(oscreen), 32'd0);

`ifdef VGA_SCREEN_FORCE_EN
    iforce_en = 1'b1; iforce_screen = 2'd2;
    frame(1'b0, 1'b0);
    chk("force_2", 32'(oscreen), 32'd2);
    iforce_screen = 2'd3;
    repeat (3) frame(1'b0, 1'b0);
    chk("force_3_maps_0", 32'(oscreen), 32'd0);
    iforce_en = 1'b0;
    repeat (3) frame(1'b0, 1'b0);
    chk("release_hold", 32'(oscreen), 32'd0);
    frame(1'b0, 1'b0);
    chk("release_rotate", 32'(oscreen), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
